// File: rtl/vdp1_cmd_fetch.sv
`default_nettype none
// ----------------------------------------------------------------------------
// vdp1_cmd_fetch: walks the VDP1 command list and hands tables to the draw
// engine. Optional VDP1_CMD_LOOP_GUARD_EN caps tables per frame. Rev 1.0
// ----------------------------------------------------------------------------
module vdp1_cmd_fetch #(
  parameter int MAX_CMDS = 16384
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  output logic [17:0]  vram_a,
  output logic         vram_rd,
  input  logic         vram_rdy,
  input  logic [15:0]  vram_d,
  output logic         cmd_valid,
  input  logic         cmd_ready,
  output logic [255:0] cmd_tbl,
  output logic [15:0]  copr,
  output logic [15:0]  lopr,
  output logic         cef,
  output logic         busy
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FETCH   = 3'd1,
    S_PRESENT = 3'd2,
    S_NEXT    = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  localparam logic [15:0] c_mask_ctrl = 16'hFF3F;
  localparam logic [15:0] c_mask_link = 16'hFFFC;
  localparam logic [15:0] c_mask_pmod = 16'h9FFF;
  localparam logic [15:0] c_mask_size = 16'h3FFF;

  state_t      r_state, w_state_nxt;
  logic [17:0] r_tp, r_ret;
  logic        r_ret_vld;
  logic [3:0]  r_widx;
  logic [15:0] r_word [0:14];
  logic        r_rd, r_cef, r_busy;
  logic [15:0] r_lopr;

  logic        w_cap, w_end, w_skip_done, w_tbl_done, w_xfer, w_retire, w_guard_hit;
  logic [15:0] w_mask, w_din;
  logic [17:0] w_tp_seq, w_tp_next;

  assign w_cap       = (r_state == S_FETCH) && r_rd && vram_rdy;
  assign w_din       = vram_d & w_mask;
  assign w_end       = w_cap && (r_widx == 4'd0) && w_din[15];
  assign w_skip_done = w_cap && (r_widx == 4'd1) && r_word[0][14];
  assign w_tbl_done  = w_cap && (r_widx == 4'd14);
  assign w_xfer      = (r_state == S_PRESENT) && cmd_ready;
  assign w_retire    = w_skip_done || w_xfer;
  assign w_tp_seq    = r_tp + 18'd16;

  always_comb begin
    w_mask = 16'hFFFF;
    case (r_widx)
      4'd0:    w_mask = c_mask_ctrl;
      4'd1:    w_mask = c_mask_link;
      4'd2:    w_mask = c_mask_pmod;
      4'd5:    w_mask = c_mask_size;
      default: w_mask = 16'hFFFF;
    endcase
  end

  always_comb begin
    w_tp_next = w_tp_seq;
    case (r_word[0][13:12])
      2'b01:   w_tp_next = {r_word[1], 2'b00};
      2'b10:   w_tp_next = {r_word[1], 2'b00};
      2'b11:   w_tp_next = r_ret_vld ? r_ret : w_tp_seq;
      default: w_tp_next = w_tp_seq;
    endcase
  end

`ifdef VDP1_CMD_LOOP_GUARD_EN
  localparam int c_cnt_w = $clog2(MAX_CMDS + 1);
  logic [c_cnt_w-1:0] r_cmd_cnt;

  // Every word-0 fetch counts, so a cyclic list of skip tables is caught too.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cmd_cnt <= '0;
    end else if (start) begin
      r_cmd_cnt <= '0;
    end else if (w_cap && (r_widx == 4'd0) && !w_guard_hit) begin
      r_cmd_cnt <= r_cmd_cnt + 1'b1;
    end
  end

  assign w_guard_hit = (r_cmd_cnt >= c_cnt_w'(MAX_CMDS));
`else
  assign w_guard_hit = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (start) begin
      w_state_nxt = S_FETCH;
    end else begin
      case (r_state)
        S_FETCH: begin
          if (w_end || (w_retire && w_guard_hit)) w_state_nxt = S_DONE;
          else if (w_skip_done)                   w_state_nxt = S_NEXT;
          else if (w_tbl_done)                    w_state_nxt = S_PRESENT;
        end
        S_PRESENT: if (w_xfer) w_state_nxt = w_guard_hit ? S_DONE : S_NEXT;
        S_NEXT:    w_state_nxt = S_FETCH;
        default:   w_state_nxt = r_state;
      endcase
    end
  end

  // A start always enters FETCH with the read request low for one cycle, which
  // also abandons any read that was in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tp      <= '0;
      r_ret     <= '0;
      r_ret_vld <= 1'b0;
      r_widx    <= '0;
      r_rd      <= 1'b0;
      r_cef     <= 1'b0;
      r_busy    <= 1'b0;
      r_lopr    <= '0;
      for (int i = 0; i < 15; i++) r_word[i] <= '0;
    end else if (start) begin
      r_tp      <= '0;
      r_widx    <= '0;
      r_rd      <= 1'b0;
      r_cef     <= 1'b0;
      r_busy    <= 1'b1;
      r_ret_vld <= 1'b0;
    end else begin
      case (r_state)
        S_FETCH: begin
          if (!r_rd) begin
            r_rd <= 1'b1;
          end else if (w_cap) begin
            r_word[r_widx] <= w_din;
            if (w_end) begin
              r_rd   <= 1'b0;
              r_cef  <= 1'b1;
              r_busy <= 1'b0;
            end else if (w_skip_done) begin
              r_rd   <= 1'b0;
              r_lopr <= copr;
              if (w_guard_hit) begin
                r_cef  <= 1'b1;
                r_busy <= 1'b0;
              end
            end else if (w_tbl_done) begin
              r_rd <= 1'b0;
            end else begin
              r_widx <= r_widx + 4'd1;
            end
          end
        end
        S_PRESENT: begin
          if (w_xfer) begin
            r_lopr <= copr;
            if (w_guard_hit) begin
              r_cef  <= 1'b1;
              r_busy <= 1'b0;
            end
          end
        end
        S_NEXT: begin
          r_tp   <= w_tp_next;
          r_widx <= '0;
          r_rd   <= 1'b1;
          if (r_word[0][13:12] == 2'b10) begin
            r_ret     <= w_tp_seq;
            r_ret_vld <= 1'b1;
          end else if (r_word[0][13:12] == 2'b11) begin
            r_ret_vld <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    cmd_tbl = '0;
    for (int i = 0; i < 15; i++) cmd_tbl[255 - 16*i -: 16] = r_word[i];
  end

  assign vram_a    = r_tp + {14'd0, r_widx};
  assign vram_rd   = r_rd;
  assign cmd_valid = (r_state == S_PRESENT);
  assign copr      = r_tp[17:2];
  assign lopr      = r_lopr;
  assign cef       = r_cef;
  assign busy      = r_busy;

endmodule
`default_nettype wire
